// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory path: arbiter FSM states, port owner and word width.
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection between fetch and data requests.
// ARB_RR_EN selects round-robin on a tie; otherwise data always wins.
module arb_pick
    import cpu_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  logic   i_flush,
    input  owner_t last,
    output logic   gnt,
    output owner_t own
);

    logic i_ok;

    // A fetch being flushed this cycle is not a candidate at all.
    assign i_ok = i_req & ~i_flush;

`ifdef ARB_RR_EN
    always_comb begin
        gnt = d_req | i_ok;
        own = OWN_D;
        if (d_req && i_ok) begin
            own = (last == OWN_D) ? OWN_I : OWN_D;
        end else if (!d_req) begin
            own = OWN_I;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt = d_req | i_ok;
        own = OWN_D;
        if (!d_req) begin
            own = OWN_I;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and fixed-latency sequencer for the unified single-ported memory.
// Define ARB_RR_EN for round-robin tie breaking instead of fixed data priority.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int LATENCY = 4  // 1..15, fits the 4-bit wait counter
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    input  logic              i_flush,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              i_ack,
    output logic [WORD_W-1:0] i_rdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);

    // Handshake: a requester raises req with its address/data and holds them
    // until the one-cycle ack; in the cycle after the ack it must drop req or
    // present a new request. A killed fetch gets no ack at all.

    state_t     state, state_n;
    owner_t     owner, own_pick, last;
    logic       wr;
    logic [3:0] cnt;
    logic       kill, kill_n;
    logic       gnt, grant, grant_wr, capture;

    arb_pick u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .i_flush (i_flush),
        .last    (last),
        .gnt     (gnt),
        .own     (own_pick)
    );

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= OWN_D;
        end else if (grant) begin
            last <= own_pick;
        end
    end
`else
    assign last = OWN_D;
`endif

    always_comb begin
        state_n  = state;
        kill_n   = kill;
        grant    = 1'b0;
        grant_wr = (own_pick == OWN_D) && d_wr;
        capture  = (state == WAIT) && (cnt == 4'd0);
        case (state)
            IDLE: begin
                kill_n = 1'b0;
                if (gnt) begin
                    grant   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE:   state_n = wr ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Flush seen in the final WAIT cycle must still suppress the ack.
        if ((state == ISSUE || state == WAIT) && owner == OWN_I && i_flush) begin
            kill_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            wr        <= 1'b0;
            cnt       <= 4'd0;
            kill      <= 1'b0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state  <= state_n;
            kill   <= kill_n;
            mem_en <= grant;
            mem_wr <= grant && grant_wr;
            busy   <= (state_n != IDLE);
            i_ack  <= (state_n == RESP) && (owner == OWN_I) && !kill_n;
            d_ack  <= (state_n == RESP) && (owner == OWN_D);

            if (grant) begin
                owner <= own_pick;
                wr    <= grant_wr;
                if (own_pick == OWN_D) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_addr  <= i_addr;
                end
            end

            if (state == ISSUE) begin
                cnt <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (state == ISSUE && wr) begin
                d_rdata <= '0;
            end
            if (capture) begin
                if (owner == OWN_D) begin
                    d_rdata <= mem_rdata;
                end else if (!kill_n) begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed requests, expected acks queued
// at issue time and compared by an independent ack monitor.
module tb_mem_arbiter;

  localparam int W = 16;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic         i_req = 0, i_flush = 0, d_req = 0, d_wr = 0;
  logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic         i_ack, d_ack, mem_en, mem_wr, busy;
  logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;

  logic         l1_d_req = 0;
  logic [W-1:0] l1_d_addr = '0;
  logic         l1_zero = 1'b0;
  logic [W-1:0] l1_zero_w = '0;
  logic         l1_i_ack, l1_d_ack, l1_mem_en, l1_mem_wr, l1_busy;
  logic [W-1:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
  logic [W-1:0] l1_mem_rdata = '0;

  logic [W-1:0] mem_model [int];
  logic [2*W:0] exp_q[$];

  mem_arbiter #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_ack(i_ack), .i_rdata(i_rdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .i_req(l1_zero), .i_addr(l1_zero_w), .i_flush(l1_zero),
    .d_req(l1_d_req), .d_wr(l1_zero), .d_addr(l1_d_addr), .d_wdata(l1_zero_w),
    .i_ack(l1_i_ack), .i_rdata(l1_i_rdata), .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return 16'h5A5A;
  endfunction

  // memory models: data is presented only in the single cycle it is valid
  initial begin : mem_main
    int vcyc;
    logic [W-1:0] raddr;
    vcyc = -1;
    raddr = '0;
    forever begin
      @(negedge clk);
      if (mem_en && mem_wr) mem_model[int'(mem_addr)] = mem_wdata;
      if (mem_en && !mem_wr) begin
        vcyc = cyc + LAT;
        raddr = mem_addr;
      end
      mem_rdata = (cyc == vcyc) ? mem_rd(raddr) : {cyc[7:0], 8'hA5};
    end
  end

  initial begin : mem_l1
    int vcyc;
    logic [W-1:0] raddr;
    vcyc = -1;
    raddr = '0;
    forever begin
      @(negedge clk);
      if (l1_mem_en && !l1_mem_wr) begin
        vcyc = cyc + 1;
        raddr = l1_mem_addr;
      end
      l1_mem_rdata = (cyc == vcyc) ? mem_rd(raddr) : {cyc[7:0], 8'h3C};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // owner bit (1 = data), data, absolute ack cycle
  task automatic push_exp(input logic is_d, input logic [W-1:0] data, input int c);
    exp_q.push_back({is_d, data, c[W-1:0]});
  endtask

  // scoreboard monitor
  initial forever begin
    logic [2*W:0] act, exp;
    @(negedge clk);
    if (!rst && (i_ack || d_ack)) begin
      act = {d_ack, d_ack ? d_rdata : i_rdata, cyc[W-1:0]};
      if (i_ack && d_ack) begin
        n_checks++;
        n_errors++;
        $display("FAIL ack_exclusive: both acks high at cycle %0d", cyc);
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: got %0h with nothing expected", act);
      end else begin
        exp = exp_q.pop_front();
        check("ack", 64'(act), 64'(exp));
      end
    end
  end

  // requesters drop req in the cycle after their ack
  initial forever begin
    @(negedge clk);
    if (d_ack) begin
      @(posedge clk);
      #1 d_req = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (i_ack) begin
      @(posedge clk);
      #1 i_req = 1'b0;
    end
  end

  // driver tasks
  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!busy && !d_req && !i_req) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: busy=%0b still set after 64 cycles", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic d_read(input logic [W-1:0] a);
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = a;
  endtask

  initial begin
    int base;
    mem_model[16'h0040] = 16'hBEEF;
    mem_model[16'h0000] = 16'h1111;
    mem_model[16'h0010] = 16'h2222;
    mem_model[16'h0020] = 16'h3333;
    mem_model[16'h0002] = 16'h4444;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({busy, mem_en, mem_wr, i_ack, d_ack, mem_addr, mem_wdata}), 64'd0);
    check("reset_rdata", 64'({i_rdata, d_rdata}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // data read of 0x0040
    base = cyc;
    push_exp(1'b1, 16'hBEEF, base + 6);
    d_read(16'h0040);
    at_cycle(base + 1);
    check("rd_mem_en", 64'(mem_en), 64'd1);
    check("rd_mem_wr", 64'(mem_wr), 64'd0);
    check("rd_mem_addr", 64'(mem_addr), 64'h0040);
    at_cycle(base + 2);
    check("rd_mem_en_pulse", 64'(mem_en), 64'd0);
    wait_idle();

    // tie: fetch 0x0000 versus data write 0x1234 -> 0x0100
    base = cyc;
`ifdef ARB_RR_EN
    push_exp(1'b0, 16'h1111, base + 6);
    push_exp(1'b1, 16'h0000, base + 9);
`else
    push_exp(1'b1, 16'h0000, base + 2);
    push_exp(1'b0, 16'h1111, base + 9);
`endif
    i_req = 1'b1;
    i_addr = 16'h0000;
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h0100;
    d_wdata = 16'h1234;
`ifdef ARB_RR_EN
    at_cycle(base + 1);
    check("tie_first_addr", 64'({mem_en, mem_wr, mem_addr}), 64'({2'b10, 16'h0000}));
    at_cycle(base + 8);
    check("tie_second_wr", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'({2'b11, 16'h0100, 16'h1234}));
`else
    at_cycle(base + 1);
    check("tie_first_wr", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'({2'b11, 16'h0100, 16'h1234}));
    at_cycle(base + 4);
    check("tie_second_addr", 64'({mem_en, mem_wr, mem_addr}), 64'({2'b10, 16'h0000}));
`endif
    wait_idle();

    // read back the stored word
    base = cyc;
    push_exp(1'b1, 16'h1234, base + 6);
    d_read(16'h0100);
    wait_idle();

    // flush a fetch of 0x0010 during WAIT, then fetch 0x0020
    base = cyc;
    i_req = 1'b1;
    i_addr = 16'h0010;
    at_cycle(base + 2);
    @(posedge clk);
    #1;
    i_flush = 1'b1;
    i_req = 1'b0;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    push_exp(1'b0, 16'h3333, base + 13);
    i_req = 1'b1;
    i_addr = 16'h0020;
    for (int k = 4; k <= 6; k++) begin
      at_cycle(base + k);
      check("flush_busy", 64'(busy), 64'd1);
    end
    check("flush_rdata_kept", 64'(i_rdata), 64'h1111);
    at_cycle(base + 7);
    check("flush_idle", 64'(busy), 64'd0);
    at_cycle(base + 8);
    check("flush_refetch_addr", 64'({mem_en, mem_addr}), 64'({1'b1, 16'h0020}));
    wait_idle();

    // reset in the middle of a read
    base = cyc;
    d_read(16'h0040);
    at_cycle(base + 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    d_req = 1'b0;
    #1;
    check("async_reset_outputs",
          64'({busy, mem_en, mem_wr, i_ack, d_ack, mem_addr, mem_wdata}), 64'd0);
    check("async_reset_rdata", 64'({i_rdata, d_rdata}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_reset_idle", 64'(busy), 64'd0);
    wait_idle();
    base = cyc;
    push_exp(1'b1, 16'h4444, base + LAT + 2);
    d_read(16'h0002);
    wait_idle();

    // LATENCY=1 instance: back-to-back reads of 0x0000 and 0x0002
    base = cyc;
    l1_d_req = 1'b1;
    l1_d_addr = 16'h0000;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) l1_d_addr = 16'h0002;
      if (k == 8) l1_d_req = 1'b0;
      @(negedge clk);
      check($sformatf("l1_mem_en_c%0d", k), 64'(l1_mem_en), 64'(k == 1 || k == 5));
      check($sformatf("l1_ack_c%0d", k), 64'({l1_d_ack, l1_i_ack}), 64'({k == 3 || k == 7, 1'b0}));
      if (k == 3) check("l1_data0", 64'(l1_d_rdata), 64'h1111);
      if (k == 7) check("l1_data2", 64'(l1_d_rdata), 64'h4444);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single-ported unified memory shared by instruction fetch and the data-memory stage of the 16-bit CPU. It accepts a read request from fetch and a read/write request from the memory stage, the latter driven by the decoder's memenable/memwrite. It grants one request at a time and drives the memory port for a fixed-latency access. It then returns read data with a one-cycle acknowledge to the winning requester.

## Interface
- LATENCY, 4, cycles from the memory-enable cycle to the cycle in which mem_rdata is valid; legal range 1–15
- WORD_W, 16, address and data width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- i_req  input  1  fetch read request; held until i_ack
- i_addr  input  WORD_W  fetch address
- i_flush  input  1  abandon the in-flight or pending fetch (taken branch)
- d_req  input  1  data request (memenable); held until d_ack
- d_wr  input  1  1 = write (memwrite), 0 = read
- d_addr  input  WORD_W  data address
- d_wdata  input  WORD_W  store data
- i_ack  output  1  one-cycle pulse; fetch done
- i_rdata  output  WORD_W  fetch data, valid with i_ack
- d_ack  output  1  one-cycle pulse; data access done
- d_rdata  output  WORD_W  load data, valid with d_ack; 0 on writes
- mem_en  output  1  one-cycle memory strobe
- mem_wr  output  1  write qualifier for mem_en
- mem_addr  output  WORD_W  latched address
- mem_wdata  output  WORD_W  latched store data
- mem_rdata  input  WORD_W  memory read data
- busy  output  1  1 in any state other than IDLE

## Operation
- States:
  - IDLE: grant when any request is present.
  - ISSUE: drive mem_en for one cycle.
  - WAIT: count LATENCY cycles on reads; skipped on writes.
  - RESP: pulse the ack for one cycle.
  - RESP always returns to IDLE.
- Grant in IDLE: d_req has priority over i_req. i_req is granted only when d_req is low and i_flush is low.
- At grant, latch the owner, d_wr, address and wdata. Requester inputs are ignored until the next IDLE.
- Read: ISSUE → WAIT. A 4-bit counter loads LATENCY-1 in ISSUE and decrements in WAIT. When it reaches 0, capture mem_rdata into the owner's rdata register and go to RESP.
- Write: ISSUE → RESP. mem_wr = 1 in ISSUE only.
- RESP: ack = 1 for the owner. The other ack is 0.
- i_flush while the fetch owns the port (ISSUE/WAIT): the access runs to completion on memory and the state sequence is unchanged. A sticky kill bit suppresses i_ack in RESP and leaves i_rdata unchanged.
- i_flush in IDLE blocks the fetch grant for that cycle only.
- The ack cycle never re-grants. A requester must drop req, or present a new address, in the cycle after its ack.
- mem_addr and mem_wdata hold their last values outside ISSUE. mem_en and mem_wr are 0 outside ISSUE.

## Timing
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE, counter to 0, kill bit to 0.
- Read latency, req sampled in IDLE cycle t:
  - mem_en in t+1
  - mem_rdata sampled at the end of t+1+LATENCY
  - ack in t+2+LATENCY
  - IDLE in t+3+LATENCY
- Write latency: mem_en in t+1, ack in t+2, IDLE in t+3.
- Reset asserted mid-transaction: all outputs go to 0 immediately, with no ack for the aborted access. Any late memory data is ignored.
- Simultaneous i_req and d_req in IDLE: the priority rule applies. The loser waits with req held.

## Configuration
- ARB_RR_EN defined: on a tie, round-robin replaces fixed priority.
  - A last-grant bit resets to "data", so the first tie goes to fetch.
  - The bit updates on every grant; the winner of a tie is the requester that was not granted last.
- ARB_RR_EN undefined: fixed data priority as above, and no last-grant register exists.

## Structure
- cpu_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - the owner enum (OWN_I, OWN_D)
  - WORD_W
- Sub-module arb_pick, combinational: inputs i_req, d_req, i_flush and last-grant; outputs grant-valid and owner. It contains the only ARB_RR_EN-dependent logic.

## Test plan
- Reset, then data read: d_req=1, d_wr=0, d_addr=0x0040, memory returns 0xBEEF with LATENCY=4. Expect mem_en=1 and mem_addr=0x0040 at cycle 1, then d_ack=1 and d_rdata=0xBEEF at cycle 6.
- Tie, fixed priority: i_req with 0x0000 and a d write of 0x1234 to 0x0100, both asserted at cycle 0.
  - Expect mem_en with mem_wr=1 at cycle 1 and d_ack at cycle 2.
  - Then the fetch: mem_en at cycle 4 and i_ack at cycle 9.
  - With ARB_RR_EN defined, the fetch goes first instead: i_ack at cycle 6, then the write with mem_en at cycle 8 and d_ack at cycle 9.
- Flush: fetch of 0x0010 granted, i_flush pulsed in WAIT. Expect no i_ack and busy=1 through cycle 6. A new i_req for 0x0020 is granted at cycle 7 and acked with the correct data.
- Reset mid-WAIT: rst pulsed at cycle 3 of a read. Expect all outputs 0 from the reset edge and no ack. After release, a data read of 0x0002 completes in LATENCY+2 cycles.
- LATENCY=1: a read gives mem_en at t+1 and ack at t+3. Back-to-back data reads at 0x0000 and 0x0002 produce acks exactly 4 cycles apart.
